wr_addr_cntrl: RTL and testbench

WR_ADDR_CNTRL -- requirements
Module: wr_addr_cntrl

---
 rtl/mmaps_pkg.sv | 21 ++
 rtl/wr_addr_cntrl.sv | 158 +++++++++++++++
 tb/tb_wr_addr_cntrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmaps_pkg.sv
// Shared definitions for the acquisition memory map: default ring buffer
// address width and the write-side acquisition state encoding.
package mmaps_pkg;

    // Ring buffer address width; depth is 2**SIZE_DEFAULT samples.
    localparam int SIZE_DEFAULT = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } wr_state_t;

    // States in which incoming samples are written to the buffer.
    function automatic logic is_writing(input wr_state_t s);
        return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/wr_addr_cntrl.sv
// Write address controller for the acquisition ring buffer. Fills the buffer
// once after arm, then writes continuously while waiting for a trigger,
// collects a programmable number of post-trigger samples and freezes the
// buffer until the read side has finished a readout.
module wr_addr_cntrl
    import mmaps_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            arm,
    input  logic            sample_valid,
    input  logic            trigger,
    input  logic [SIZE-1:0] posttrig_i,
    input  logic            rd_request,
    output logic [SIZE-1:0] wr_addr,
    output logic            wr_en,
    output logic [SIZE-1:0] ain,
    output logic [SIZE-1:0] trig_addr,
    output logic            full,
    output logic            ready
);

    localparam logic [SIZE-1:0] ADDR_ONE  = SIZE'(1);
    localparam logic [SIZE:0]   FILL_ONE  = (SIZE + 1)'(1);
    // Fill count value just before the write that completes the buffer.
    localparam logic [SIZE:0]   FILL_LAST = {1'b0, {SIZE{1'b1}}};

    wr_state_t       state_reg, state_next;
    logic [SIZE-1:0] wr_addr_reg, wr_addr_next;
    logic [SIZE:0]   fill_cnt_reg, fill_cnt_next;
    logic [SIZE-1:0] post_cnt_reg, post_cnt_next;
    logic [SIZE-1:0] trig_addr_reg, trig_addr_next;
    logic            full_reg, full_next;
    logic            ready_reg;
    logic            seen_reg, seen_next;
    logic            rd_q_reg, rd_q2_reg;
    logic            write_c;
    logic            rd_rise, rd_fall;

    // A write happens whenever a sample arrives in a writing state; reset
    // suppresses it so nothing is written in the reset cycle.
    assign write_c = sample_valid & is_writing(state_reg) & ~rst;
    assign rd_rise = rd_q_reg & ~rd_q2_reg;
    assign rd_fall = ~rd_q_reg & rd_q2_reg;

    assign wr_en     = write_c;
    assign wr_addr   = wr_addr_reg;
    assign ain       = wr_addr_reg;
    assign trig_addr = trig_addr_reg;
    assign full      = full_reg;
    assign ready     = ready_reg;

    // Next-state and counter update logic for the acquisition cycle.
    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        fill_cnt_next  = fill_cnt_reg;
        post_cnt_next  = post_cnt_reg;
        trig_addr_next = trig_addr_reg;
        full_next      = full_reg;
        seen_next      = seen_reg;

        if (write_c) begin
            wr_addr_next = wr_addr_reg + ADDR_ONE;
        end

        case (state_reg)
            ST_IDLE: begin
                if (arm) begin
                    state_next    = ST_FILL;
                    wr_addr_next  = '0;
                    fill_cnt_next = '0;
                    full_next     = 1'b0;
                end
            end
            ST_FILL: begin
                if (!arm) begin
                    state_next = ST_IDLE;
                    full_next  = 1'b0;
                end else if (write_c) begin
                    fill_cnt_next = fill_cnt_reg + FILL_ONE;
                    // Triggers are ignored here, even on the completing write.
                    if (fill_cnt_reg == FILL_LAST) begin
                        full_next  = 1'b1;
                        state_next = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    state_next = ST_IDLE;
                    full_next  = 1'b0;
                end else if (trigger) begin
                    // Pre-increment address: a sample written this cycle is pre-trigger.
                    trig_addr_next = wr_addr_reg;
                    post_cnt_next  = posttrig_i;
                    state_next     = (posttrig_i == '0) ? ST_HOLD : ST_POST;
                end
            end
            ST_POST: begin
                if (!arm) begin
                    state_next = ST_IDLE;
                    full_next  = 1'b0;
                end else if (write_c) begin
                    post_cnt_next = post_cnt_reg - ADDR_ONE;
                    if (post_cnt_reg == ADDR_ONE) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Readout completes on a falling edge that follows a seen rising edge.
                if (rd_fall && seen_reg) begin
                    state_next    = arm ? ST_FILL : ST_IDLE;
                    seen_next     = 1'b0;
                    fill_cnt_next = '0;
                    full_next     = 1'b0;
                end else if (rd_rise) begin
                    seen_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides every transition.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_addr_reg   <= '0;
            fill_cnt_reg  <= '0;
            post_cnt_reg  <= '0;
            trig_addr_reg <= '0;
            full_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            seen_reg      <= 1'b0;
            rd_q_reg      <= 1'b0;
            rd_q2_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_addr_reg   <= wr_addr_next;
            fill_cnt_reg  <= fill_cnt_next;
            post_cnt_reg  <= post_cnt_next;
            trig_addr_reg <= trig_addr_next;
            full_reg      <= full_next;
            ready_reg     <= (state_next == ST_HOLD);
            seen_reg      <= seen_next;
            // rd_request only matters while frozen; outside HOLD it reads as 0.
            rd_q_reg      <= (state_reg == ST_HOLD) & rd_request;
            rd_q2_reg     <= rd_q_reg;
        end
    end

endmodule

// File: tb/tb_wr_addr_cntrl.sv
// Self-checking bench for wr_addr_cntrl: directed acquisition scenarios
// followed by randomized traffic, checked every cycle against a
// count-based behavioural model through an expectation queue.
module tb_wr_addr_cntrl;

    localparam int SIZE  = 12;
    localparam int DEPTH = 1 << SIZE;

    localparam int PH_IDLE  = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_ARMED = 2;
    localparam int PH_POST  = 3;
    localparam int PH_HOLD  = 4;

    logic            sysclk = 1'b0;
    logic            rst = 1'b1;
    logic            arm = 1'b0;
    logic            sample_valid = 1'b0;
    logic            trigger = 1'b0;
    logic [SIZE-1:0] posttrig_i = '0;
    logic            rd_request = 1'b0;
    logic [SIZE-1:0] wr_addr;
    logic            wr_en;
    logic [SIZE-1:0] ain;
    logic [SIZE-1:0] trig_addr;
    logic            full;
    logic            ready;

    always #5 sysclk = ~sysclk;

    wr_addr_cntrl #(.SIZE(SIZE)) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .arm          (arm),
        .sample_valid (sample_valid),
        .trigger      (trigger),
        .posttrig_i   (posttrig_i),
        .rd_request   (rd_request),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .ain          (ain),
        .trig_addr    (trig_addr),
        .full         (full),
        .ready        (ready)
    );

    typedef struct packed {
        logic            wr_en;
        logic [SIZE-1:0] wr_addr;
        logic [SIZE-1:0] ain;
        logic [SIZE-1:0] trig_addr;
        logic            full;
        logic            ready;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;

    // Behavioural model: phase, address as a plain integer modulo DEPTH,
    // number of samples written since the fill began, samples still owed
    // after the trigger, and the last two rd_request values seen in HOLD.
    int m_phase, m_addr, m_trig, m_filled, m_post_left;
    bit m_full, m_h1, m_h2, m_rose;

    task automatic model_reset();
        m_phase = PH_IDLE; m_addr = 0; m_trig = 0; m_filled = 0; m_post_left = 0;
        m_full = 0; m_h1 = 0; m_h2 = 0; m_rose = 0;
    endtask

    task automatic enter_hold();
        m_phase = PH_HOLD; m_h1 = 0; m_h2 = 0; m_rose = 0;
    endtask

    // Records the outputs expected during this cycle, then advances the model.
    task automatic model_step(input bit a, input bit sv, input bit tr, input int pt,
                              input bit rd, input bit r);
        obs_t e;
        bit   wr;
        int   old_addr;
        wr = sv && !r && (m_phase == PH_FILL || m_phase == PH_ARMED || m_phase == PH_POST);
        e.wr_en     = wr;
        e.wr_addr   = SIZE'(m_addr);
        e.ain       = SIZE'(m_addr);
        e.trig_addr = SIZE'(m_trig);
        e.full      = m_full;
        e.ready     = (m_phase == PH_HOLD);
        exp_q.push_back(e);
        pushed++;
        if (r) begin
            model_reset();
            return;
        end
        old_addr = m_addr;
        if (m_phase == PH_IDLE) begin
            if (a) begin
                m_phase = PH_FILL; m_addr = 0; m_filled = 0; m_full = 0;
            end
        end else if (m_phase == PH_HOLD) begin
            if (!m_h1 && m_h2 && m_rose) begin
                m_phase = a ? PH_FILL : PH_IDLE; m_filled = 0; m_full = 0;
            end else begin
                if (m_h1 && !m_h2) m_rose = 1;
                m_h2 = m_h1;
                m_h1 = rd;
            end
        end else begin
            if (wr) m_addr = (m_addr + 1) % DEPTH;
            if (!a) begin
                m_phase = PH_IDLE; m_full = 0;
            end else if (m_phase == PH_FILL) begin
                if (wr) m_filled++;
                if (m_filled == DEPTH) begin
                    m_full = 1; m_phase = PH_ARMED;
                end
            end else if (m_phase == PH_ARMED) begin
                if (tr) begin
                    m_trig = old_addr;
                    if (pt == 0) enter_hold();
                    else begin
                        m_post_left = pt; m_phase = PH_POST;
                    end
                end
            end else begin
                if (wr) begin
                    m_post_left--;
                    if (m_post_left == 0) enter_hold();
                end
            end
        end
    endtask

    // One clock of stimulus: inputs applied 1 time unit after the rising edge.
    task automatic drive(input bit a, input bit sv, input bit tr, input int pt,
                         input bit rd, input bit r);
        arm = a; sample_valid = sv; trigger = tr; posttrig_i = SIZE'(pt);
        rd_request = rd; rst = r;
        model_step(a, sv, tr, pt, rd, r);
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic check_phase(input string name, input int want);
        checks++;
        if (m_phase != want) begin
            failures++;
            $display("FAIL %s cycle budget expired, phase got=%0d expected=%0d", name, m_phase, want);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare it
    // with the oldest queued expectation on the falling edge.
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(negedge sysclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                got = {wr_en, wr_addr, ain, trig_addr, full, ready};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got we=%0b addr=%h ain=%h trig=%h full=%0b rdy=%0b expected we=%0b addr=%h ain=%h trig=%h full=%0b rdy=%0b",
                             $time, got.wr_en, got.wr_addr, got.ain, got.trig_addr, got.full, got.ready,
                             e.wr_en, e.wr_addr, e.ain, e.trig_addr, e.full, e.ready);
                end else begin
                    $display("cycle t=%0t we=%0b addr=%h trig=%h full=%0b rdy=%0b ok",
                             $time, got.wr_en, got.wr_addr, got.trig_addr, got.full, got.ready);
                end
            end
        end
    end

    initial begin
        int n;
        bit rd_lvl;
        bit a_lvl;
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        drive(0, 0, 0, 0, 0, 1);
        check_val("reset_wr_addr", int'(wr_addr), 0);
        check_val("reset_ready", int'(ready), 0);

        // Continuous fill with stray triggers and rd pulses, incl. on the final fill write.
        n = 0;
        while (m_phase != PH_ARMED && n < 5000) begin
            drive(1, 1, ($urandom % 8 == 0) || (m_filled == DEPTH - 1), 5,
                  ($urandom % 16 == 0), 0);
            n++;
        end
        check_phase("fill_to_armed", PH_ARMED);
        check_val("armed_entry_addr", int'(wr_addr), 0);
        check_val("armed_full", int'(full), 1);
        check_val("fill_trig_untouched", int'(trig_addr), 0);

        // Zero post-trigger count at the top address: frozen with wrapped pointer.
        n = 0;
        while (m_addr != DEPTH - 1 && n < 5000) begin
            drive(1, 1, 0, 0, 0, 0);
            n++;
        end
        drive(1, 1, 1, 0, 0, 0);
        check_phase("zero_post_hold", PH_HOLD);
        check_val("wrap_ain", int'(ain), 0);
        check_val("wrap_ready", int'(ready), 1);
        check_val("wrap_trig", int'(trig_addr), DEPTH - 1);

        // Readout with arm held: back to FILL, pointer continues.
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        repeat (20) drive(1, 1, 0, 0, 1, 0);
        n = 0;
        while (m_phase == PH_HOLD && n < 10) begin
            drive(1, 0, 0, 0, 0, 0);
            n++;
        end
        check_phase("readout_to_fill", PH_FILL);
        check_val("readout_ready_low", int'(ready), 0);
        check_val("readout_full_low", int'(full), 0);
        check_val("readout_ain_kept", int'(ain), 0);

        // Trigger at 0x123 with no sample in the trigger cycle, 16 post samples.
        n = 0;
        while (m_phase != PH_ARMED && n < 20000) begin
            drive(1, ($urandom % 4 != 0), 0, 0, 0, 0);
            n++;
        end
        check_phase("refill_to_armed", PH_ARMED);
        n = 0;
        while (m_addr != 'h123 && n < 5000) begin
            drive(1, 1, 0, 0, 0, 0);
            n++;
        end
        drive(1, 0, 1, 16, 0, 0);
        n = 0;
        while (m_phase == PH_POST && n < 200) begin
            drive(1, ($urandom % 2 == 0), 0, 0, 0, 0);
            n++;
        end
        check_phase("post_to_hold", PH_HOLD);
        check_val("post_trig_addr", int'(trig_addr), 'h123);
        check_val("post_ain", int'(ain), 'h133);
        check_val("post_ready", int'(ready), 1);

        // Readout with arm low: IDLE.
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 1, 0);
        n = 0;
        while (m_phase == PH_HOLD && n < 10) begin
            drive(0, 0, 0, 0, 0, 0);
            n++;
        end
        check_phase("readout_to_idle", PH_IDLE);
        check_val("idle_ready_low", int'(ready), 0);

        // Reset in the middle of POST.
        n = 0;
        while (m_phase != PH_POST && n < 5000) begin
            drive(1, 1, (m_phase == PH_ARMED), 100, 0, 0);
            n++;
        end
        repeat (5) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1);
        check_val("rst_post_wr_addr", int'(wr_addr), 0);
        check_val("rst_post_trig", int'(trig_addr), 0);
        check_val("rst_post_full", int'(full), 0);
        check_val("rst_post_ready", int'(ready), 0);

        // Randomized traffic.
        rd_lvl = 0;
        a_lvl = 1;
        for (int i = 0; i < 30000; i++) begin
            if ($urandom % 6 == 0) rd_lvl = ~rd_lvl;
            if ($urandom % 3000 == 0) a_lvl = ~a_lvl;
            if (!a_lvl && $urandom % 20 == 0) a_lvl = 1;
            drive(a_lvl, ($urandom % 4 != 0), ($urandom % 64 == 0),
                  ($urandom % 2 == 0) ? $urandom_range(0, 20) : $urandom_range(0, DEPTH - 1),
                  rd_lvl, ($urandom % 15000 == 0));
        end
        drive(0, 0, 0, 0, 0, 0);

        @(negedge sysclk);
        @(negedge sysclk);
        check_val("queue_drained", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
